// File: rtl/snake_pkg.sv
// Shared snake-game definitions: FSM encoding, playfield bounds, coordinate widths.
// Imported by the game controller, the snake mover and the apple generator.
package snake_pkg;

    localparam int X_W = 6;
    localparam int Y_W = 5;

    typedef logic [2:0] game_state_t;

    localparam game_state_t ST_IDLE  = 3'd0;
    localparam game_state_t ST_PLAY  = 3'd1;
    localparam game_state_t ST_PAUSE = 3'd2;
    localparam game_state_t ST_DYING = 3'd3;
    localparam game_state_t ST_OVER  = 3'd4;

    localparam int GRID_X_MIN = 1;
    localparam int GRID_X_MAX = 38;
    localparam int GRID_Y_MIN = 1;
    localparam int GRID_Y_MAX = 28;

    // Shorter move interval after an apple, clamped so it never drops below the floor.
    function automatic logic [31:0] sped_up_period(input logic [31:0] period,
                                                   input logic [31:0] min_period,
                                                   input logic [31:0] step);
        if (period >= min_period + step)
            return period - step;
        return min_period;
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Programmable-period move tick: counts while enabled, pulses on the last count of each interval.
// The period is sampled at clear and at every wrap, so changes land on the next interval.
module snake_tick_gen #(
    parameter int unsigned RST_PERIOD = 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [31:0] period_i,
    output logic        tick_o
);

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] per_q, per_d;
    logic        term;

    assign term   = (cnt_q == per_q - 32'd1);
    assign tick_o = en_i && term;

    always_comb begin
        cnt_d = cnt_q;
        per_d = per_q;
        if (clr_i) begin
            cnt_d = '0;
            per_d = period_i;
        end else if (en_i) begin
            if (term) begin
                cnt_d = '0;
                per_d = period_i;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            per_q <= RST_PERIOD;
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: game FSM, move tick pacing, wall/self collision check,
// length and speed tracking from apple pulses, and the death flash timer.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned BASE_PERIOD   = 250000,
    parameter int unsigned MIN_PERIOD    = 50000,
    parameter int unsigned SPEED_STEP    = 10000,
    parameter int unsigned X_MIN         = GRID_X_MIN,
    parameter int unsigned X_MAX         = GRID_X_MAX,
    parameter int unsigned Y_MIN         = GRID_Y_MIN,
    parameter int unsigned Y_MAX         = GRID_Y_MAX,
    parameter int unsigned INIT_LEN      = 3,
    parameter int unsigned MAX_LEN       = 63,
    parameter int unsigned FLASH_PERIOD  = 25000000,
    parameter int unsigned FLASH_TOGGLES = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_btn,
    input  logic           pause_btn,
    input  logic [X_W-1:0] head_x,
    input  logic [Y_W-1:0] head_y,
    input  logic           self_hit,
    input  logic           apple_eat,
    output logic           move_tick,
    output logic           soft_clr,
    output logic [2:0]     game_state,
    output logic [5:0]     snake_len,
    output logic           flash,
    output logic           game_over
);

    localparam logic [X_W-1:0] X_LO       = X_W'(X_MIN);
    localparam logic [X_W-1:0] X_HI       = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LO       = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0] Y_HI       = Y_W'(Y_MAX);
    localparam logic [5:0]     LEN_INIT   = 6'(INIT_LEN);
    localparam logic [5:0]     LEN_MAX    = 6'(MAX_LEN);
    localparam logic [31:0]    FLASH_LAST = 32'(FLASH_PERIOD - 1);
    localparam logic [7:0]     TOG_LAST   = 8'(FLASH_TOGGLES - 1);

    game_state_t state_q, state_d;
    logic [5:0]  len_q, len_d;
    logic [31:0] period_q, period_d;
    logic [31:0] fcnt_q, fcnt_d;
    logic [7:0]  tog_q, tog_d;
    logic        flash_q, flash_d;
    logic        chk_q, apple_q;

    logic in_play, wall, collide, apple_rise, tick_en, restart;

    // The mover registers its new head one cycle after a tick, so the check looks one cycle late.
    assign in_play    = (state_q == ST_PLAY);
    assign wall       = (head_x < X_LO) || (head_x > X_HI) || (head_y < Y_LO) || (head_y > Y_HI);
    assign collide    = in_play && chk_q && (wall || self_hit);
    assign apple_rise = in_play && apple_eat && !apple_q && !collide;
    assign tick_en    = in_play && !pause_btn && !collide;
    assign restart    = rst && start_btn && ((state_q == ST_IDLE) || (state_q == ST_OVER));

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        period_d = period_q;
        flash_d  = flash_q;
        fcnt_d   = fcnt_q;
        tog_d    = tog_q;
        if (apple_rise) begin
            len_d    = (len_q == LEN_MAX) ? len_q : len_q + 6'd1;
            period_d = sped_up_period(period_q, MIN_PERIOD, SPEED_STEP);
        end
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (restart) begin
                    state_d  = ST_PLAY;
                    len_d    = LEN_INIT;
                    period_d = BASE_PERIOD;
                    flash_d  = 1'b0;
                end
            end
            ST_PLAY: begin
                if (collide) begin
                    state_d = ST_DYING;
                    fcnt_d  = '0;
                    tog_d   = '0;
                end else if (pause_btn) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_btn)
                    state_d = ST_PLAY;
            end
            ST_DYING: begin
                if (fcnt_q == FLASH_LAST) begin
                    fcnt_d  = '0;
                    flash_d = !flash_q;
                    tog_d   = tog_q + 8'd1;
                    if (tog_q == TOG_LAST) begin
                        state_d = ST_OVER;
                        flash_d = 1'b0;
                    end
                end else begin
                    fcnt_d = fcnt_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            len_q    <= LEN_INIT;
            period_q <= BASE_PERIOD;
            fcnt_q   <= '0;
            tog_q    <= '0;
            flash_q  <= 1'b0;
            chk_q    <= 1'b0;
            apple_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            period_q <= period_d;
            fcnt_q   <= fcnt_d;
            tog_q    <= tog_d;
            flash_q  <= flash_d;
            chk_q    <= move_tick;
            apple_q  <= apple_eat;
        end
    end

    // period_d is handed over so a restart or a same-cycle apple lands in the next interval.
    snake_tick_gen #(
        .RST_PERIOD(BASE_PERIOD)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (restart),
        .en_i    (tick_en),
        .period_i(period_d),
        .tick_o  (move_tick)
    );

    assign soft_clr   = restart;
    assign game_state = state_q;
    assign snake_len  = len_q;
    assign flash      = flash_q;
    assign game_over  = (state_q == ST_OVER);

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Randomised bench for snake_game_ctrl: a countdown-based game model predicts output events
// into a queue, and a negedge monitor pops and compares each event the DUT presents.
module tb_snake_game_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_btn, pause_btn, self_hit, apple_eat;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic       move_tick, soft_clr, flash, game_over;
    logic [2:0] game_state;
    logic [5:0] snake_len;

    always #5 clk = ~clk;

    snake_game_ctrl #(
        .BASE_PERIOD(10), .MIN_PERIOD(4), .SPEED_STEP(2),
        .FLASH_PERIOD(3), .FLASH_TOGGLES(4)
    ) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn),
        .head_x(head_x), .head_y(head_y), .self_hit(self_hit), .apple_eat(apple_eat),
        .move_tick(move_tick), .soft_clr(soft_clr), .game_state(game_state),
        .snake_len(snake_len), .flash(flash), .game_over(game_over)
    );

    typedef struct {
        int         cyc;
        logic       tick;
        logic       sclr;
        logic [2:0] st;
        logic [5:0] len;
        logic       fl;
        logic       go;
    } ev_t;

    ev_t q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    bit  mon_en  = 0;

    // Game model: 0 idle, 1 play, 2 pause, 3 dying, 4 over.
    int m_st, m_len, m_per, m_left, m_dcyc;
    bit m_chk, m_ap, m_fl;
    int last_st, last_len;
    bit last_fl;

    task automatic model_reset();
        m_st = 0; m_len = 3; m_per = 10; m_left = 10; m_dcyc = 0;
        m_chk = 0; m_ap = 0; m_fl = 0;
    endtask

    task automatic push_if_event(input bit tick, input bit sclr);
        ev_t e;
        e.cyc = cyc; e.tick = tick; e.sclr = sclr; e.st = 3'(m_st);
        e.len = 6'(m_len); e.fl = m_fl; e.go = (m_st == 4);
        if (tick || sclr || m_st != last_st || m_len != last_len || m_fl != last_fl)
            q.push_back(e);
        last_st = m_st; last_len = m_len; last_fl = m_fl;
    endtask

    task automatic step(input bit s, input bit p, input int hx, input int hy,
                        input bit sh, input bit ap);
        bit sclr, hit, run, tick, rise;
        cyc++;
        start_btn = s; pause_btn = p; head_x = 6'(hx); head_y = 5'(hy);
        self_hit = sh; apple_eat = ap;
        sclr = s && (m_st == 0 || m_st == 4);
        hit  = (m_st == 1) && m_chk && (hx < 1 || hx > 38 || hy < 1 || hy > 28 || sh);
        run  = (m_st == 1) && !p && !hit;
        tick = run && (m_left == 1);
        push_if_event(tick, sclr);
        rise = (m_st == 1) && ap && !m_ap && !hit;
        m_ap = ap;
        if (rise) begin
            m_len = (m_len + 1 > 63) ? 63 : m_len + 1;
            m_per = (m_per - 2 < 4) ? 4 : m_per - 2;
        end
        if (run) m_left = tick ? m_per : m_left - 1;
        m_chk = tick;
        case (m_st)
            0, 4: if (s) begin m_st = 1; m_len = 3; m_per = 10; m_left = 10; m_fl = 0; end
            1: if (hit) begin m_st = 3; m_dcyc = 0; end else if (p) m_st = 2;
            2: if (p) m_st = 1;
            3: begin
                m_dcyc++;
                if (m_dcyc % 3 == 0) begin
                    m_fl = !m_fl;
                    if (m_dcyc / 3 == 4) begin m_st = 4; m_fl = 0; end
                end
            end
            default: ;
        endcase
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        cyc++;
        rst = 1'b0;
        start_btn = 0; pause_btn = 0; self_hit = 0; apple_eat = 0;
        model_reset();
        push_if_event(1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic idle(input int n, input bit ap);
        for (int i = 0; i < n; i++)
            step(0, 0, $urandom_range(38, 1), $urandom_range(28, 1), 0, ap);
    endtask

    task automatic chk_val(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end else begin
            $display("[TB] ok %s = %0d", nm, act);
        end
    endtask

    // Monitor: one comparison per DUT event, plus one per predicted event the DUT never showed.
    logic [2:0] p_st  = 3'd0;
    logic [5:0] p_len = 6'd3;
    logic       p_fl  = 1'b0;
    ev_t        me;
    logic       dut_ev;
    always @(negedge clk) begin
        if (mon_en) begin
            dut_ev = move_tick || soft_clr || (game_state != p_st) || (snake_len != p_len) || (flash != p_fl);
            if (dut_ev) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event cyc=%0d: tick=%0b clr=%0b st=%0d len=%0d fl=%0b, expected no event",
                             cyc, move_tick, soft_clr, game_state, snake_len, flash);
                end else begin
                    me = q.pop_front();
                    if (me.cyc != cyc || me.tick !== move_tick || me.sclr !== soft_clr || me.st !== game_state ||
                        me.len !== snake_len || me.fl !== flash || me.go !== game_over) begin
                        n_fail++;
                        $display("FAIL event cyc=%0d: got tick=%0b clr=%0b st=%0d len=%0d fl=%0b go=%0b, expected cyc=%0d tick=%0b clr=%0b st=%0d len=%0d fl=%0b go=%0b",
                                 cyc, move_tick, soft_clr, game_state, snake_len, flash, game_over,
                                 me.cyc, me.tick, me.sclr, me.st, me.len, me.fl, me.go);
                    end else begin
                        $display("[TB] ok cyc=%0d tick=%0b clr=%0b st=%0d len=%0d fl=%0b",
                                 cyc, move_tick, soft_clr, game_state, snake_len, flash);
                    end
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                me = q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missing_event cyc=%0d: got no event (st=%0d len=%0d), expected tick=%0b clr=%0b st=%0d len=%0d fl=%0b",
                         cyc, game_state, snake_len, me.tick, me.sclr, me.st, me.len, me.fl);
            end
            p_st = game_state; p_len = snake_len; p_fl = flash;
        end
    end

    task automatic wait_model(input int mode, input int limit);
        // mode 0: counter at 5 in play; 1: terminal count in play; 2: check cycle
        for (int k = 0; k < limit; k++) begin
            if (mode == 0 && m_st == 1 && m_left == 5) return;
            if (mode == 1 && m_st == 1 && m_left == 1) return;
            if (mode == 2 && m_st == 1 && m_chk) return;
            idle(1, 0);
        end
        n_tests++; n_fail++;
        $display("FAIL wait_model mode=%0d: got no match in %0d cycles, expected one", mode, limit);
    endtask

    initial begin
        int hx, hy;
        bit ap, p, s, sh;
        rst = 1'b0;
        start_btn = 0; pause_btn = 0; self_hit = 0; apple_eat = 0; head_x = 6'd5; head_y = 5'd5;
        model_reset();
        last_st = 0; last_len = 3; last_fl = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_val("reset_game_state", game_state, 0);
        chk_val("reset_snake_len", snake_len, 3);
        chk_val("reset_move_tick", move_tick, 0);
        chk_val("reset_soft_clr", soft_clr, 0);
        chk_val("reset_flash", flash, 0);
        chk_val("reset_game_over", game_over, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1;

        // Start, then pause at counter 5 and resume.
        step(1, 0, 5, 5, 0, 0);
        idle(25, 0);
        wait_model(0, 20);
        step(0, 1, 5, 5, 0, 0);
        idle(50, 0);
        step(0, 1, 5, 5, 0, 0);
        idle(12, 0);

        // Long apple level, then four more edges down to the period floor.
        idle(20, 1);
        idle(7, 0);
        for (int i = 0; i < 4; i++) begin
            idle($urandom_range(4, 1), 1);
            idle($urandom_range(9, 4), 0);
        end
        idle(20, 0);

        // Pause on the terminal count suppresses the tick.
        wait_model(1, 20);
        step(0, 1, 5, 5, 0, 0);
        idle(8, 0);
        step(0, 1, 5, 5, 0, 0);
        idle(10, 0);

        // Wall hit at x=39, with buttons pressed while dying.
        wait_model(2, 20);
        step(0, 0, 39, 5, 0, 0);
        idle(4, 0);
        step(1, 0, 5, 5, 0, 0);
        step(0, 1, 5, 5, 0, 0);
        idle(14, 0);

        // Restart from OVER; self-hit and apple edge coincide at the check.
        step(1, 0, 5, 5, 0, 0);
        idle(3, 0);
        wait_model(2, 20);
        step(0, 0, 7, 7, 1, 1);
        idle(5, 1);
        do_reset();
        idle(3, 0);

        // Length saturation.
        step(1, 0, 5, 5, 0, 0);
        for (int i = 0; i < 66; i++) begin
            idle(2, 1);
            idle(2, 0);
        end
        idle(6, 0);

        // Random games.
        for (int g = 0; g < 4; g++) begin
            if (!(m_st == 0 || m_st == 4)) do_reset();
            step(1, 0, 5, 5, 0, 0);
            ap = 0;
            for (int k = 0; k < 500 && m_st != 4; k++) begin
                p  = ($urandom_range(39, 0) == 0);
                s  = ($urandom_range(49, 0) == 0);
                sh = 0;
                hx = $urandom_range(38, 1);
                hy = $urandom_range(28, 1);
                if ($urandom_range(5, 0) == 0) ap = !ap;
                if (m_chk && $urandom_range(11, 0) == 0) begin
                    case ($urandom_range(3, 0))
                        0: hx = 0;
                        1: hx = $urandom_range(63, 39);
                        2: hy = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(31, 29);
                        default: sh = 1;
                    endcase
                end
                step(s, p, hx, hy, sh, ap);
            end
        end

        idle(3, 0);
        @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending events, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
